pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
- Shares the graphic manager's single pixel-write port between two requesters.
- Requester 0 is the painter (touch strokes and ROM frame loads). Requester 1 is the result/overlay writer.
- Each requester issues fire-and-forget write strobes into a private FIFO.
- The arbiter drains both FIFOs round-robin, with an optional lock so a full-frame load is not interleaved. Output uses a valid/ready handshake towards the graphic manager.

Parameters:
- FIFO_DEPTH, 4, entries per requester FIFO; power of two, minimum 2.
- H_RES, 320, horizontal resolution; legal columns are 0..H_RES-1.
- V_RES, 240, vertical resolution; legal rows are 0..V_RES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  block enable
- initialized  in  1  graphic manager has finished LCD init
- r0_write  in  1  one-cycle pixel strobe, requester 0
- r0_col  in  9  column, requester 0
- r0_row  in  8  row, requester 0
- r0_color  in  1  black/white colour, requester 0
- r0_lock  in  1  hold grant while high, requester 0
- r0_full  out  1  FIFO 0 full
- r0_ovf  out  1  sticky: a strobe to FIFO 0 was dropped
- r1_write, r1_col, r1_row, r1_color, r1_lock, r1_full, r1_ovf  same widths and meanings for requester 1
- gm_ready  in  1  graphic manager accepts a pixel this cycle
- write_pixel  out  1  output valid
- pixel_col  out  9  output column
- pixel_row  out  8  output row
- bw_pixel_color  out  1  output colour
- grant  out  2  one-hot owner of the current/last output; 00 in idle

Behaviour:
- Reset (reset low, asynchronous):
  - Every output is 0.
  - FIFOs are emptied, ovf flags cleared, round-robin pointer set to requester 0, state IDLE.
- Push:
  - rK_write and en high, and FIFO K count < FIFO_DEPTH or a pop of K happens in the same cycle -> entry stored.
  - Otherwise the strobe is dropped and rK_ovf is set. rK_ovf clears only on reset.
  - rK_full equals (count == FIFO_DEPTH), registered.
- Output stage: a one-entry register.
  - The transfer completes on any cycle with write_pixel and gm_ready both high.
  - While write_pixel is high and gm_ready is low, pixel_col, pixel_row and bw_pixel_color hold stable.
  - The output register loads the next pixel on a transfer cycle or when empty. Back-to-back throughput is 1 pixel/clk when gm_ready stays high.
- Pops are allowed only when en and initialized are both high.
  - When either is low, no new pixel is loaded.
  - A pixel already in the output register still completes its handshake.
- Latency: a strobe at cycle t into an empty system gives write_pixel high at t+2.
- State machine:
  - IDLE -> G0 or G1 when either FIFO is non-empty. The round-robin pointer chooses if both are non-empty.
  - A lock asserted with an empty FIFO takes the grant anyway. If both locks assert in IDLE, requester 0 wins.
  - In GK: one pixel is popped from FIFO K per load opportunity.
    - Unlocked: after each pop the pointer moves to the other requester. The next load goes to the other FIFO if it is non-empty, else K again; if both are empty -> IDLE.
    - rK_lock high: the grant stays K even if FIFO K is empty, and the other FIFO is starved.
    - Lock falls: the pointer points to the other requester and arbitration resumes at the next load.
- grant reflects the source of the pixel in the output register and holds its value while write_pixel is high.
- en low: pushes are ignored (the ovf flags are not set by these) and the state freezes. The output handshake still completes.
- No reordering within a requester: the FIFO order is preserved.

Optional Feature:
- Macro PIXEL_ARB_CLIP_EN.
- When defined:
  - Entries with col >= H_RES or row >= V_RES are popped and discarded without being presented; grant does not change.
  - Two extra outputs, r0_clip and r1_clip (1 bit each), are sticky flags set on each discard and cleared on reset.
- When undefined: coordinates pass through unchecked and the clip ports do not exist.

Test Plan:
- Reset low mid-burst with 3 entries queued -> next clk: write_pixel=0, grant=00, r0_full=0, r0_ovf=0. After release, the outputs stay idle until new strobes arrive.
- initialized=0, 5 r0 strobes with FIFO_DEPTH=4 -> no write_pixel, r0_full=1, r0_ovf=1. Set initialized=1 with gm_ready=1 -> exactly 4 pixels out, in push order.
- Both requesters push 3 pixels each in the same cycles, gm_ready=1 -> output sources alternate 0,1,0,1,0,1 (grant 01,10,...).
- r0_lock=1 with r1 holding 2 pixels, then 3 r0 strobes spaced 5 clks apart -> only r0 pixels emerge. r1 pixels emerge after r0_lock falls.
- gm_ready held low 10 clks with write_pixel=1 at col=100, row=50 -> values stable all 10 cycles. Transfer occurs on the first cycle gm_ready=1.
- PIXEL_ARB_CLIP_EN: push (col=320,row=10), then (col=5,row=239) -> only (5,239) is written, and r0_clip=1.

Source files
------------

// File: rtl/pixel_write_arbiter_if.sv
// Valid/ready pixel write bus between the arbiter (master) and the graphic manager (slave).
interface pixel_write_arbiter_if;
    logic       write_pixel;
    logic [8:0] pixel_col;
    logic [7:0] pixel_row;
    logic       bw_pixel_color;
    logic       gm_ready;

    modport master (output write_pixel, pixel_col, pixel_row, bw_pixel_color, input gm_ready);
    modport slave  (input write_pixel, pixel_col, pixel_row, bw_pixel_color, output gm_ready);
endinterface

// File: rtl/pixel_write_arbiter.sv
// Two-requester round-robin pixel write arbiter with per-requester FIFOs and grant lock.
// Optional macro PIXEL_ARB_CLIP_EN discards off-screen entries and adds r0_clip/r1_clip.

module pixel_write_arbiter_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_next;
    logic          push_req, push, do_pop;

    assign empty    = (count == '0);
    assign dout     = mem[rptr];
    assign push_req = wr & en;
    assign do_pop   = pop & ~empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push       = push_req & ((count != DEPTH_C) | do_pop);
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (push)   wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            if (push_req && !push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

module pixel_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_RES      = 320,
    parameter int V_RES      = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       initialized,
    input  logic       r0_write,
    input  logic [8:0] r0_col,
    input  logic [7:0] r0_row,
    input  logic       r0_color,
    input  logic       r0_lock,
    output logic       r0_full,
    output logic       r0_ovf,
    input  logic       r1_write,
    input  logic [8:0] r1_col,
    input  logic [7:0] r1_row,
    input  logic       r1_color,
    input  logic       r1_lock,
    output logic       r1_full,
    output logic       r1_ovf,
`ifdef PIXEL_ARB_CLIP_EN
    output logic       r0_clip,
    output logic       r1_clip,
`endif
    pixel_write_arbiter_if.master gm,
    output logic [1:0] grant
);
    localparam int NUM_REQ = 2;
    localparam int PW      = 18;
`ifdef PIXEL_ARB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] col;
        logic [7:0] row;
        logic       color;
    } pix_t;

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    logic [NUM_REQ-1:0]         wr, lock, pop, empty, full, ovf;
    logic [NUM_REQ-1:0][PW-1:0] din, dout;

    assign wr     = {r1_write, r0_write};
    assign lock   = {r1_lock, r0_lock};
    assign din[0] = {r0_col, r0_row, r0_color};
    assign din[1] = {r1_col, r1_row, r1_color};
    assign {r1_full, r0_full} = full;
    assign {r1_ovf,  r0_ovf}  = ovf;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        pixel_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .W(PW)) u_fifo (
            .clk(clk), .reset(reset), .en(en),
            .wr(wr[k]), .din(din[k]),
            .pop(pop[k]), .dout(dout[k]),
            .empty(empty[k]), .full(full[k]), .ovf(ovf[k])
        );
    end

    state_t state, state_next;
    logic   rr, rr_next, own, owner_locked, sel, sel_vld;
    logic   can_load, xfer, pop_any, load, head_oob, drop;
    logic   out_vld;
    pix_t   head, out_q;

    assign own          = (state == G1);
    assign owner_locked = (state != IDLE) && lock[own];
    assign xfer         = out_vld & gm.gm_ready;
    assign can_load     = en & initialized & (~out_vld | gm.gm_ready);
    assign head         = pix_t'(dout[sel]);
    assign head_oob     = ({23'd0, head.col} >= H_RES) || ({24'd0, head.row} >= V_RES);
    assign drop         = CLIP & head_oob;
    assign pop_any      = can_load & sel_vld & ~empty[sel];
    assign load         = pop_any & ~drop;
    assign pop          = pop_any ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // A locking owner keeps the grant; otherwise any lock wins (r0 first), then round-robin.
    always_comb begin
        sel        = rr;
        sel_vld    = 1'b0;
        state_next = state;
        rr_next    = rr;
        if (owner_locked) begin
            sel     = own;
            sel_vld = 1'b1;
        end else if (lock[0]) begin
            sel     = 1'b0;
            sel_vld = 1'b1;
        end else if (lock[1]) begin
            sel     = 1'b1;
            sel_vld = 1'b1;
        end else if (!empty[rr]) begin
            sel_vld = 1'b1;
        end else if (!empty[~rr]) begin
            sel     = ~rr;
            sel_vld = 1'b1;
        end
        if (can_load) state_next = !sel_vld ? IDLE : (sel ? G1 : G0);
        if (en && owner_locked) rr_next = ~own;
        else if (pop_any)       rr_next = ~sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rr      <= 1'b0;
            out_vld <= 1'b0;
            out_q   <= '0;
            grant   <= '0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            if (load) begin
                out_vld <= 1'b1;
                out_q   <= head;
                grant   <= sel ? 2'b10 : 2'b01;
            end else if (xfer) begin
                out_vld <= 1'b0;
                if (state_next == IDLE) grant <= '0;
            end
        end
    end

`ifdef PIXEL_ARB_CLIP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_clip <= 1'b0;
            r1_clip <= 1'b0;
        end else if (pop_any && drop) begin
            if (sel) r1_clip <= 1'b1;
            else     r0_clip <= 1'b1;
        end
    end
`endif

    assign gm.write_pixel    = out_vld;
    assign gm.pixel_col      = out_q.col;
    assign gm.pixel_row      = out_q.row;
    assign gm.bw_pixel_color = out_q.color;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: reset, overflow, latency, round-robin, lock, backpressure, enable, clip.
module tb_pixel_write_arbiter;
    logic clk = 1'b0, reset = 1'b0, en = 1'b0, initialized = 1'b0;
    logic r0_write = 1'b0, r0_color = 1'b0, r0_lock = 1'b0;
    logic [8:0] r0_col = '0;
    logic [7:0] r0_row = '0;
    logic r1_write = 1'b0, r1_color = 1'b0, r1_lock = 1'b0;
    logic [8:0] r1_col = '0;
    logic [7:0] r1_row = '0;
    logic r0_full, r0_ovf, r1_full, r1_ovf;
`ifdef PIXEL_ARB_CLIP_EN
    logic r0_clip, r1_clip;
`endif
    logic [1:0] grant;

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] got_d[$];
    logic [1:0]  got_g[$];

    pixel_write_arbiter_if pif();

    pixel_write_arbiter #(.FIFO_DEPTH(4), .H_RES(320), .V_RES(240)) dut (
        .clk(clk), .reset(reset), .en(en), .initialized(initialized),
        .r0_write(r0_write), .r0_col(r0_col), .r0_row(r0_row), .r0_color(r0_color),
        .r0_lock(r0_lock), .r0_full(r0_full), .r0_ovf(r0_ovf),
        .r1_write(r1_write), .r1_col(r1_col), .r1_row(r1_row), .r1_color(r1_color),
        .r1_lock(r1_lock), .r1_full(r1_full), .r1_ovf(r1_ovf),
`ifdef PIXEL_ARB_CLIP_EN
        .r0_clip(r0_clip), .r1_clip(r1_clip),
`endif
        .gm(pif), .grant(grant)
    );

    always #5 clk = ~clk;

    // Record every completed transfer (valid and ready both high mid-cycle).
    always @(negedge clk) begin
        if (reset && pif.write_pixel && pif.gm_ready) begin
            got_d.push_back({pif.pixel_col, pif.pixel_row, pif.bw_pixel_color});
            got_g.push_back(grant);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push1(input bit k, input logic [8:0] c, input logic [7:0] r, input logic colr);
        if (k) begin r1_write = 1'b1; r1_col = c; r1_row = r; r1_color = colr; end
        else   begin r0_write = 1'b1; r0_col = c; r0_row = r; r0_color = colr; end
        tick(1);
        r0_write = 1'b0;
        r1_write = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b0; en = 1'b0; initialized = 1'b0; pif.gm_ready = 1'b0;
        r0_write = 1'b0; r1_write = 1'b0; r0_lock = 1'b0; r1_lock = 1'b0;
        tick(2);
        got_d.delete();
        got_g.delete();
        reset = 1'b1;
        en = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        pif.gm_ready = 1'b0;
        tick(1);
        n_checks++;
        if ({pif.write_pixel, grant, r0_full, r0_ovf, r1_full, r1_ovf} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wp=%b grant=%b f0=%b o0=%b f1=%b o1=%b, expected all 0",
                     pif.write_pixel, grant, r0_full, r0_ovf, r1_full, r1_ovf);
        end
        reset = 1'b1; en = 1'b1; initialized = 1'b1;
        for (int i = 0; i < 3; i++) push1(1'b0, 9'(i + 1), 8'd1, 1'b1);
        n_checks++;
        if (pif.write_pixel !== 1'b1 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_preburst: got wp=%b grant=%b, expected 1 01", pif.write_pixel, grant);
        end
        reset = 1'b0;
        tick(1);
        n_checks++;
        if ({pif.write_pixel, grant, r0_full, r0_ovf} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_midburst: got wp=%b grant=%b f0=%b o0=%b, expected 0",
                     pif.write_pixel, grant, r0_full, r0_ovf);
        end
        reset = 1'b1;
        pif.gm_ready = 1'b1;
        tick(6);
        n_checks++;
        if (got_d.size() != 0 || pif.write_pixel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_after: got %0d transfers wp=%b, expected 0 0", got_d.size(), pif.write_pixel);
        end
    endtask

    task automatic test_overflow;
        logic [17:0] exp;
        apply_reset();
        pif.gm_ready = 1'b1;
        for (int i = 0; i < 5; i++) push1(1'b0, 9'(i + 1), 8'(i + 10), i[0]);
        n_checks++;
        if (pif.write_pixel !== 1'b0 || r0_full !== 1'b1 || r0_ovf !== 1'b1 || r1_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flags: got wp=%b full=%b ovf=%b ovf1=%b, expected 0 1 1 0",
                     pif.write_pixel, r0_full, r0_ovf, r1_ovf);
        end
        initialized = 1'b1;
        tick(10);
        n_checks++;
        if (got_d.size() != 4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d pixels, expected 4", got_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                exp = {9'(i + 1), 8'(i + 10), i[0]};
                n_checks++;
                if (got_d[i] !== exp || got_g[i] !== 2'b01) begin
                    n_fail++;
                    $display("FAIL ovf_order[%0d]: got %h/%b, expected %h/01", i, got_d[i], got_g[i], exp);
                end
            end
        end
        n_checks++;
        if (r0_full !== 1'b0 || r0_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got full=%b ovf=%b, expected 0 1", r0_full, r0_ovf);
        end
    endtask

    task automatic test_latency;
        apply_reset();
        initialized = 1'b1;
        pif.gm_ready = 1'b1;
        push1(1'b1, 9'd33, 8'd44, 1'b1);
        n_checks++;
        if (pif.write_pixel !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_t1: got wp=%b, expected 0", pif.write_pixel);
        end
        tick(1);
        n_checks++;
        if (pif.write_pixel !== 1'b1 || grant !== 2'b10 || pif.pixel_col !== 9'd33 || pif.pixel_row !== 8'd44) begin
            n_fail++;
            $display("FAIL latency_t2: got wp=%b grant=%b col=%0d row=%0d, expected 1 10 33 44",
                     pif.write_pixel, grant, pif.pixel_col, pif.pixel_row);
        end
    endtask

    task automatic test_round_robin;
        logic [17:0] exp;
        logic [1:0]  expg;
        apply_reset();
        initialized = 1'b1;
        pif.gm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r0_write = 1'b1; r0_col = 9'(10 + i); r0_row = 8'd1; r0_color = 1'b0;
            r1_write = 1'b1; r1_col = 9'(20 + i); r1_row = 8'd2; r1_color = 1'b1;
            tick(1);
        end
        r0_write = 1'b0;
        r1_write = 1'b0;
        tick(10);
        n_checks++;
        if (got_d.size() != 6) begin
            n_fail++;
            $display("FAIL rr_count: got %0d pixels, expected 6", got_d.size());
        end
        for (int j = 0; j < 6; j++) begin
            if (j < got_d.size()) begin
                exp  = j[0] ? {9'(20 + j / 2), 8'd2, 1'b1} : {9'(10 + j / 2), 8'd1, 1'b0};
                expg = j[0] ? 2'b10 : 2'b01;
                n_checks++;
                if (got_d[j] !== exp || got_g[j] !== expg) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %h/%b, expected %h/%b", j, got_d[j], got_g[j], exp, expg);
                end
            end
        end
        n_checks++;
        if (grant !== 2'b00 || pif.write_pixel !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: got grant=%b wp=%b, expected 00 0", grant, pif.write_pixel);
        end
    endtask

    task automatic test_lock;
        apply_reset();
        initialized = 1'b1;
        pif.gm_ready = 1'b1;
        r0_lock = 1'b1;
        tick(1);
        push1(1'b1, 9'd200, 8'd3, 1'b0);
        push1(1'b1, 9'd201, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push1(1'b0, 9'(50 + i), 8'd7, 1'b1);
            tick(4);
        end
        tick(5);
        n_checks++;
        if (got_d.size() != 3) begin
            n_fail++;
            $display("FAIL lock_starve: got %0d pixels, expected 3", got_d.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got_d.size()) begin
                n_checks++;
                if (got_d[i] !== {9'(50 + i), 8'd7, 1'b1} || got_g[i] !== 2'b01) begin
                    n_fail++;
                    $display("FAIL lock_r0[%0d]: got %h/%b, expected col %0d grant 01", i, got_d[i], got_g[i], 50 + i);
                end
            end
        end
        r0_lock = 1'b0;
        tick(6);
        n_checks++;
        if (got_d.size() != 5) begin
            n_fail++;
            $display("FAIL lock_release: got %0d pixels, expected 5", got_d.size());
        end else begin
            n_checks++;
            if (got_d[3] !== {9'd200, 8'd3, 1'b0} || got_d[4] !== {9'd201, 8'd3, 1'b0} ||
                got_g[3] !== 2'b10 || got_g[4] !== 2'b10) begin
                n_fail++;
                $display("FAIL lock_r1: got %h/%b %h/%b, expected col 200,201 grant 10",
                         got_d[3], got_g[3], got_d[4], got_g[4]);
            end
        end
    endtask

    task automatic test_backpressure;
        apply_reset();
        initialized = 1'b1;
        pif.gm_ready = 1'b0;
        push1(1'b0, 9'd100, 8'd50, 1'b1);
        push1(1'b0, 9'd7, 8'd8, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (pif.write_pixel !== 1'b1 || pif.pixel_col !== 9'd100 || pif.pixel_row !== 8'd50 ||
                pif.bw_pixel_color !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got wp=%b col=%0d row=%0d c=%b, expected 1 100 50 1",
                         i, pif.write_pixel, pif.pixel_col, pif.pixel_row, pif.bw_pixel_color);
            end
            tick(1);
        end
        pif.gm_ready = 1'b1;
        tick(1);
        n_checks++;
        if (got_d.size() != 1 || pif.write_pixel !== 1'b1 || pif.pixel_col !== 9'd7) begin
            n_fail++;
            $display("FAIL bp_release: got %0d transfers wp=%b col=%0d, expected 1 1 7",
                     got_d.size(), pif.write_pixel, pif.pixel_col);
        end else begin
            n_checks++;
            if (got_d[0] !== {9'd100, 8'd50, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_first: got %h, expected col 100 row 50 c 1", got_d[0]);
            end
        end
    endtask

    task automatic test_enable;
        apply_reset();
        en = 1'b0;
        initialized = 1'b1;
        pif.gm_ready = 1'b1;
        for (int i = 0; i < 5; i++) push1(1'b0, 9'd9, 8'd9, 1'b1);
        tick(3);
        n_checks++;
        if (r0_ovf !== 1'b0 || r0_full !== 1'b0 || pif.write_pixel !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off: got ovf=%b full=%b wp=%b, expected 0 0 0", r0_ovf, r0_full, pif.write_pixel);
        end
        en = 1'b1;
        tick(3);
        n_checks++;
        if (got_d.size() != 0) begin
            n_fail++;
            $display("FAIL en_ignored: got %0d transfers, expected 0", got_d.size());
        end
    endtask

    task automatic test_clip;
        apply_reset();
        initialized = 1'b1;
        pif.gm_ready = 1'b1;
        push1(1'b0, 9'd320, 8'd10, 1'b1);
        push1(1'b0, 9'd5, 8'd239, 1'b0);
        tick(6);
`ifdef PIXEL_ARB_CLIP_EN
        n_checks++;
        if (got_d.size() != 1 || r0_clip !== 1'b1 || r1_clip !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_drop: got %0d pixels clip0=%b clip1=%b, expected 1 1 0",
                     got_d.size(), r0_clip, r1_clip);
        end else begin
            n_checks++;
            if (got_d[0] !== {9'd5, 8'd239, 1'b0} || got_g[0] !== 2'b01) begin
                n_fail++;
                $display("FAIL clip_keep: got %h/%b, expected col 5 row 239 grant 01", got_d[0], got_g[0]);
            end
        end
`else
        n_checks++;
        if (got_d.size() != 2) begin
            n_fail++;
            $display("FAIL clip_passthru: got %0d pixels, expected 2", got_d.size());
        end else begin
            n_checks++;
            if (got_d[0] !== {9'd320, 8'd10, 1'b1} || got_d[1] !== {9'd5, 8'd239, 1'b0}) begin
                n_fail++;
                $display("FAIL clip_passthru_data: got %h %h, expected col 320 then col 5", got_d[0], got_d[1]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_latency();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_enable();
        test_clip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
